// File: rtl/axi4l_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: turns one local read/write command
// into the matching AXI4-Lite handshakes and returns the response to the requester.
module axi4l_cmd_master #(
    parameter logic [2:0] PROT  = 3'b000,
    parameter int         CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [3:0]       req_wstrb,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic [1:0]       rsp_resp,
    output logic             rsp_write,
    output logic [31:0]      m_awaddr,
    output logic [2:0]       m_awprot,
    output logic             m_awvalid,
    input  logic             m_awready,
    output logic [31:0]      m_wdata,
    output logic [3:0]       m_wstrb,
    output logic             m_wvalid,
    input  logic             m_wready,
    input  logic [1:0]       m_bresp,
    input  logic             m_bvalid,
    output logic             m_bready,
    output logic [31:0]      m_araddr,
    output logic [2:0]       m_arprot,
    output logic             m_arvalid,
    input  logic             m_arready,
    input  logic [31:0]      m_rdata,
    input  logic [1:0]       m_rresp,
    input  logic             m_rvalid,
    output logic             m_rready,
    output logic             busy,
    output logic [CNT_W-1:0] txn_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic             aw_done_q;
    logic             w_done_q;
    logic [31:0]      rdata_q;
    logic [1:0]       resp_q;
    logic             write_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // AW and W are tracked separately so each valid drops right after its own handshake.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = !rst;
                if (req_valid) begin
                    state_d = req_write ? S_WR : S_RD_ADDR;
                end
            end
            S_WR: begin
                m_awvalid = !aw_done_q;
                m_wvalid  = !w_done_q;
                if ((aw_done_q || m_awready) && (w_done_q || m_wready)) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    state_d = S_RESP;
                end
            end
            S_RD_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
            write_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr & 32'hFFFF_FFFC;
                        wdata_q   <= req_wdata;
                        wstrb_q   <= req_wstrb;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                S_WR: begin
                    if (m_awready) begin
                        aw_done_q <= 1'b1;
                    end
                    if (m_wready) begin
                        w_done_q <= 1'b1;
                    end
                end
                S_WR_RESP: begin
                    if (m_bvalid) begin
                        resp_q  <= m_bresp;
                        rdata_q <= '0;
                        write_q <= 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (m_rvalid) begin
                        resp_q  <= m_rresp;
                        rdata_q <= m_rdata;
                        write_q <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_awprot  = PROT;
    assign m_arprot  = PROT;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
    assign rsp_write = write_q;
    assign busy      = (state_q != S_IDLE);
    assign txn_cnt   = cnt_q;

endmodule
